// File: rtl/cheriot_dmem_txn_monitor.sv
// Data-memory transaction monitor: pairs granted requests with in-order
// responses and streams one record per word. Option: CHERIOT_DMON_TSMAP_FLAG_EN
package cheriot_dv_pkg;
    localparam logic [31:0] TsMapStartAddr = 32'h8300_0000;

    typedef struct packed {
        logic [7:0]  flag;
        logic        is_cap;
        logic        we;
        logic [3:0]  be;
        logic [29:0] addr32;
        logic [32:0] wdata;
        logic [32:0] rdata;
        logic        err;
    } mem_cmd_t;
endpackage

module cheriot_dmem_txn_monitor
    import cheriot_dv_pkg::*;
#(
    parameter int unsigned PendDepth = 4,
    parameter int unsigned OutDepth  = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    input  logic        data_gnt_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_is_cap_i,
    input  logic [32:0] data_wdata_i,
    input  logic        data_rvalid_i,
    input  logic [32:0] data_rdata_i,
    input  logic        data_err_i,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output mem_cmd_t    cmd_o,
    output logic [15:0] drop_cnt_o,
    output logic        pend_ovf_o,
    output logic        unexp_rvalid_o
);
    localparam int PW = $clog2(PendDepth);
    localparam int OW = $clog2(OutDepth);
    localparam logic [PW:0] PendFull = (PW+1)'(PendDepth);
    localparam logic [OW:0] OutFull  = (OW+1)'(OutDepth);

    typedef struct packed {
        logic        is_cap;
        logic        we;
        logic [3:0]  be;
        logic [29:0] addr;
        logic [32:0] wdata;
    } pend_t;

    pend_t    pend_mem [PendDepth];
    mem_cmd_t out_mem  [OutDepth];

    logic [PW-1:0] prd_q, prd_d, pwr_q, pwr_d;
    logic [PW:0]   pcnt_q, pcnt_d;
    logic [OW-1:0] ord_q, ord_d, owr_q, owr_d;
    logic [OW:0]   ocnt_q, ocnt_d;
    logic [6:0]    seq_q, seq_d;
    logic [15:0]   drop_q, drop_d;
    logic          ovf_q, ovf_d, unexp_q, unexp_d;

    logic     grant, pend_pop, pend_push, pend_empty, pend_full;
    logic     out_pop, out_push, out_full;
    logic     ts_bit;
    pend_t    head, pend_new;
    mem_cmd_t rec;
    logic     unused_addr_lsb;

    assign unused_addr_lsb = ^data_addr_i[1:0];

    // Queue bookkeeping: pending pop precedes push, output pop precedes push
    always_comb begin
        pend_empty = (pcnt_q == '0);
        pend_full  = (pcnt_q == PendFull);
        grant      = data_req_i & data_gnt_i;
        pend_pop   = data_rvalid_i & ~pend_empty;
        pend_push  = grant & (~pend_full | pend_pop);
        head       = pend_mem[prd_q];

        pend_new.is_cap = data_is_cap_i;
        pend_new.we     = data_we_i;
        pend_new.be     = data_be_i;
        pend_new.addr   = data_addr_i[31:2];
        pend_new.wdata  = data_we_i ? data_wdata_i : 33'h0;

`ifdef CHERIOT_DMON_TSMAP_FLAG_EN
        ts_bit = ({head.addr, 2'b00} >= TsMapStartAddr);
`else
        ts_bit = 1'b0;
`endif
        rec.flag   = {ts_bit, seq_q};
        rec.is_cap = head.is_cap;
        rec.we     = head.we;
        rec.be     = head.be;
        rec.addr32 = head.addr;
        rec.wdata  = head.wdata;
        rec.rdata  = head.we ? 33'h0 : data_rdata_i;
        rec.err    = data_err_i;

        out_full = (ocnt_q == OutFull);
        out_pop  = cmd_valid_o & cmd_ready_i;
        out_push = pend_pop & (~out_full | out_pop);

        prd_d  = prd_q + PW'(pend_pop);
        pwr_d  = pwr_q + PW'(pend_push);
        pcnt_d = pcnt_q + (PW+1)'(pend_push) - (PW+1)'(pend_pop);
        ord_d  = ord_q + OW'(out_pop);
        owr_d  = owr_q + OW'(out_push);
        ocnt_d = ocnt_q + (OW+1)'(out_push) - (OW+1)'(out_pop);
        seq_d  = seq_q + 7'(pend_pop);

        drop_d = drop_q;
        if (pend_pop & out_full & ~out_pop & (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
        ovf_d   = ovf_q | (grant & pend_full & ~pend_pop);
        unexp_d = unexp_q | (data_rvalid_i & pend_empty);
    end

    // Control state, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prd_q   <= '0;
            pwr_q   <= '0;
            pcnt_q  <= '0;
            ord_q   <= '0;
            owr_q   <= '0;
            ocnt_q  <= '0;
            seq_q   <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
            unexp_q <= 1'b0;
        end else begin
            prd_q   <= prd_d;
            pwr_q   <= pwr_d;
            pcnt_q  <= pcnt_d;
            ord_q   <= ord_d;
            owr_q   <= owr_d;
            ocnt_q  <= ocnt_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
            unexp_q <= unexp_d;
        end
    end

    // Queue storage; contents are only meaningful under the counters
    always_ff @(posedge clk_i) begin
        if (pend_push) begin
            pend_mem[pwr_q] <= pend_new;
        end
        if (out_push) begin
            out_mem[owr_q] <= rec;
        end
    end

    assign cmd_valid_o    = (ocnt_q != '0);
    assign cmd_o          = cmd_valid_o ? out_mem[ord_q] : '0;
    assign drop_cnt_o     = drop_q;
    assign pend_ovf_o     = ovf_q;
    assign unexp_rvalid_o = unexp_q;
endmodule

// File: tb/tb_cheriot_dmem_txn_monitor.sv
// Bench for cheriot_dmem_txn_monitor: directed table, corner sequences
// and random traffic against a queue-based reference model.
module tb_cheriot_dmem_txn_monitor;
    import cheriot_dv_pkg::*;

    localparam int PD = 4;
    localparam int OD = 8;
`ifdef CHERIOT_DMON_TSMAP_FLAG_EN
    localparam bit TS = 1'b1;
`else
    localparam bit TS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req = 0, gnt = 0, we = 0, is_cap = 0;
    logic [3:0]  be = 0;
    logic [31:0] addr = 0;
    logic [32:0] wdata = 0, rdata = 0;
    logic        rvalid = 0, err = 0, ready = 0;
    logic        cmd_valid, pend_ovf, unexp;
    mem_cmd_t    cmd;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cheriot_dmem_txn_monitor #(.PendDepth(PD), .OutDepth(OD)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .data_req_i(req), .data_gnt_i(gnt), .data_we_i(we),
        .data_be_i(be), .data_addr_i(addr), .data_is_cap_i(is_cap),
        .data_wdata_i(wdata), .data_rvalid_i(rvalid),
        .data_rdata_i(rdata), .data_err_i(err),
        .cmd_valid_o(cmd_valid), .cmd_ready_i(ready), .cmd_o(cmd),
        .drop_cnt_o(drop_cnt), .pend_ovf_o(pend_ovf),
        .unexp_rvalid_o(unexp)
    );

    // Reference model: transaction queues following the pairing rules
    mem_cmd_t    m_pend[$];
    mem_cmd_t    m_out[$];
    int          m_seq = 0;
    int          m_drop = 0;
    bit          m_ovf = 0, m_unexp = 0;

    always @(posedge clk or negedge rst_n) begin
        mem_cmd_t p, r;
        bit have;
        if (!rst_n) begin
            m_pend.delete();
            m_out.delete();
            m_seq = 0; m_drop = 0; m_ovf = 0; m_unexp = 0;
        end else begin
            have = 0;
            if (m_out.size() > 0 && ready) void'(m_out.pop_front());
            if (rvalid) begin
                if (m_pend.size() > 0) begin
                    p = m_pend.pop_front();
                    r = p;
                    r.flag = {(TS && {p.addr32, 2'b00} >= 32'h8300_0000),
                              7'(m_seq)};
                    r.rdata = p.we ? 33'h0 : rdata;
                    r.err = err;
                    m_seq = (m_seq + 1) % 128;
                    have = 1;
                end else begin
                    m_unexp = 1;
                end
            end
            if (req && gnt) begin
                if (m_pend.size() < PD) begin
                    p = '0;
                    p.is_cap = is_cap; p.we = we; p.be = be;
                    p.addr32 = addr[31:2];
                    p.wdata = we ? wdata : 33'h0;
                    m_pend.push_back(p);
                end else begin
                    m_ovf = 1;
                end
            end
            if (have) begin
                if (m_out.size() < OD) m_out.push_back(r);
                else if (m_drop < 65535) m_drop++;
            end
        end
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_cmd(string nm, mem_cmd_t act, mem_cmd_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic model_check(string nm);
        chk({nm, ".valid"}, 64'(cmd_valid), 64'(m_out.size() != 0));
        if (m_out.size() != 0) chk_cmd({nm, ".cmd"}, cmd, m_out[0]);
        chk({nm, ".drop"}, 64'(drop_cnt), 64'(m_drop));
        chk({nm, ".ovf"}, 64'(pend_ovf), 64'(m_ovf));
        chk({nm, ".unexp"}, 64'(unexp), 64'(m_unexp));
    endtask

    task automatic idle();
        req = 0; gnt = 0; we = 0; is_cap = 0; be = 0; addr = 0;
        wdata = 0; rvalid = 0; rdata = 0; err = 0;
    endtask

    task automatic cyc(string nm);
        @(posedge clk);
        @(negedge clk);
        model_check(nm);
    endtask

    task automatic do_reset(string nm);
        rst_n = 0;
        idle();
        #1;
        chk({nm, ".rst_valid"}, 64'(cmd_valid), 64'd0);
        chk_cmd({nm, ".rst_cmd"}, cmd, '0);
        chk({nm, ".rst_drop"}, 64'(drop_cnt), 64'd0);
        chk({nm, ".rst_ovf"}, 64'(pend_ovf), 64'd0);
        chk({nm, ".rst_unexp"}, 64'(unexp), 64'd0);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic rd_req(logic [31:0] a);
        req = 1; gnt = 1; we = 0; is_cap = 0; be = 4'hF; addr = a;
    endtask

    typedef struct {
        bit          rs;
        bit          rq, w, c;
        logic [31:0] a;
        logic [32:0] wd;
        bit          rv;
        logic [32:0] rd;
        bit          ev;
        mem_cmd_t    ec;
    } vec_t;

    function automatic vec_t v(bit rs, bit rq, bit w, bit c,
                               logic [31:0] a, logic [32:0] wd,
                               bit rv, logic [32:0] rd, bit ev,
                               logic [7:0] ef, bit ecap, bit ew,
                               logic [29:0] ea, logic [32:0] ewd,
                               logic [32:0] erd);
        vec_t t;
        t.rs = rs; t.rq = rq; t.w = w; t.c = c; t.a = a; t.wd = wd;
        t.rv = rv; t.rd = rd; t.ev = ev;
        t.ec.flag = ef; t.ec.is_cap = ecap; t.ec.we = ew;
        t.ec.be = 4'hF; t.ec.addr32 = ea; t.ec.wdata = ewd;
        t.ec.rdata = erd; t.ec.err = 1'b0;
        return t;
    endfunction

    vec_t tbl[14];
    int   n;

    initial begin
        tbl[0]  = v(1, 1, 0, 0, 32'h8000_0010, 33'h1_FFFF_0000, 0, 0,
                    0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = v(0, 0, 0, 0, 0, 0, 1, 33'h1_DEAD_BEEF,
                    1, 8'h00, 0, 0, 30'h2000_0004, 0, 33'h1_DEAD_BEEF);
        tbl[2]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[3]  = v(1, 1, 1, 0, 32'h100, 33'h0_1111_1111, 0, 0,
                    0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = v(0, 1, 1, 0, 32'h104, 33'h1_2222_2222, 1, 33'h1_5555_AAAA,
                    1, 8'h00, 0, 1, 30'h40, 33'h0_1111_1111, 0);
        tbl[5]  = v(0, 1, 0, 1, 32'h200, 33'h1_3333_3333, 1, 33'h1_5555_AAAA,
                    1, 8'h01, 0, 1, 30'h41, 33'h1_2222_2222, 0);
        tbl[6]  = v(0, 1, 0, 1, 32'h204, 0, 1, 33'h1_0000_00C0,
                    1, 8'h02, 1, 0, 30'h80, 0, 33'h1_0000_00C0);
        tbl[7]  = v(0, 0, 0, 0, 0, 0, 1, 33'h0_1234_5678,
                    1, 8'h03, 1, 0, 30'h81, 0, 33'h0_1234_5678);
        tbl[8]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = v(1, 1, 0, 0, 32'h8300_0004, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0);
        tbl[10] = v(0, 0, 0, 0, 0, 0, 1, 33'h0_0000_0042,
                    1, {TS, 7'd0}, 0, 0, 30'h20C0_0001, 0, 33'h42);
        tbl[11] = v(0, 1, 0, 0, 32'h82FF_FFFC, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0);
        tbl[12] = v(0, 0, 0, 0, 0, 0, 1, 33'h1,
                    1, 8'h01, 0, 0, 30'h20BF_FFFF, 0, 33'h1);
        tbl[13] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        #2;
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rs) do_reset($sformatf("tbl%0d", i));
            req = tbl[i].rq; gnt = tbl[i].rq; we = tbl[i].w;
            is_cap = tbl[i].c; be = 4'hF; addr = tbl[i].a;
            wdata = tbl[i].wd; rvalid = tbl[i].rv; rdata = tbl[i].rd;
            err = 0; ready = 1;
            cyc($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.exp_valid", i), 64'(cmd_valid),
                64'(tbl[i].ev));
            if (tbl[i].ev) chk_cmd($sformatf("tbl%0d.exp_cmd", i), cmd,
                                   tbl[i].ec);
        end
        idle();

        // Backpressure: 10 reads into an 8-deep output FIFO
        do_reset("bp");
        ready = 0;
        for (int i = 0; i < 11; i++) begin
            if (i < 10) rd_req(32'h4000 + 32'(i * 4));
            else begin req = 0; gnt = 0; end
            rvalid = (i > 0);
            rdata = 33'(i);
            cyc($sformatf("bp_fill%0d", i));
        end
        idle();
        repeat (2) cyc("bp_hold");
        chk("bp.drop", 64'(drop_cnt), 64'd2);
        chk("bp.held_addr", 64'(cmd.addr32), 64'h1000);
        chk("bp.held_flag", 64'(cmd.flag), 64'd0);
        ready = 1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (cmd_valid) begin
                chk($sformatf("bp.seq%0d", n), 64'(cmd.flag[6:0]), 64'(n));
                n++;
            end
            cyc("bp_drain");
        end
        chk("bp.drained", 64'(n), 64'd8);

        // Protocol errors: stray rvalid, then pending overflow
        do_reset("perr");
        ready = 1;
        rvalid = 1;
        cyc("perr_unexp");
        rvalid = 0;
        for (int i = 0; i < 5; i++) begin
            rd_req(32'h1000 + 32'(i * 4));
            cyc("perr_grant");
        end
        idle();
        cyc("perr_idle");
        chk("perr.unexp", 64'(unexp), 64'd1);
        chk("perr.ovf", 64'(pend_ovf), 64'd1);
        n = 0;
        for (int i = 0; i < 7; i++) begin
            rvalid = (i < 4);
            rdata = 33'h0_0BAD_0000 + 33'(i);
            cyc("perr_resp");
            if (cmd_valid) begin
                chk($sformatf("perr.seq%0d", n), 64'(cmd.flag[6:0]), 64'(n));
                chk($sformatf("perr.addr%0d", n), 64'(cmd.addr32),
                    64'(30'h400 + 30'(n)));
                n++;
            end
        end
        chk("perr.records", 64'(n), 64'd4);

        // Reset with 3 pending requests and 5 queued records
        do_reset("rm_pre");
        ready = 0;
        for (int i = 0; i < 8; i++) begin
            rd_req(32'h2000 + 32'(i * 4));
            rvalid = (i >= 1 && i <= 5);
            rdata = 33'h1_0000_0000 + 33'(i);
            cyc("rm_fill");
        end
        idle();
        chk("rm.queued", 64'(m_out.size()), 64'd5);
        chk("rm.pending", 64'(m_pend.size()), 64'd3);
        do_reset("rm");
        ready = 1;
        for (int i = 0; i < 3; i++) begin
            rvalid = (i == 0);
            cyc("rm_post");
        end
        chk("rm.no_stale", 64'(cmd_valid), 64'd0);
        chk("rm.unexp", 64'(unexp), 64'd1);

        // Random traffic against the model
        do_reset("rnd");
        for (int i = 0; i < 3000; i++) begin
            req = ($urandom_range(0, 99) < 60);
            gnt = ($urandom_range(0, 99) < 70);
            we = $urandom_range(0, 1);
            is_cap = $urandom_range(0, 1);
            be = 4'($urandom);
            addr = ($urandom_range(0, 1) != 0) ? 32'h8300_0000 + $urandom_range(0, 64)
                                               : $urandom;
            wdata = {1'($urandom), 32'($urandom)};
            rvalid = ($urandom_range(0, 99) < 45);
            rdata = {1'($urandom), 32'($urandom)};
            err = ($urandom_range(0, 99) < 10);
            ready = ((i / 200) % 3 == 2) ? ($urandom_range(0, 99) < 10)
                                         : ($urandom_range(0, 99) < 75);
            cyc("rnd");
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
